// File: rtl/res_checker.sv
// Response checker for an adder BFM: predicts (a+b) mod 2^DATA_W for every accepted
// operand pair, delays it LATENCY cycles, and scores it against the DUT result.
module res_checker #(
  parameter int DATA_W  = 8,
  parameter int LATENCY = 1,
  parameter int LENGTH  = 2000,
  parameter int CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] res_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  match_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  first_err_idx_o,
  output logic [DATA_W-1:0] first_err_exp_o,
  output logic [DATA_W-1:0] first_err_got_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LP_LEN  = CNT_W'(LENGTH);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LENGTH - 1);
  localparam logic [CNT_W-1:0] LP_MAX  = '1;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [LATENCY-1:0] r_vld;
  logic [DATA_W-1:0]  r_exp [LATENCY];
  logic [CNT_W-1:0]   r_idx [LATENCY];

  logic [CNT_W-1:0]   r_issued;
  logic [CNT_W-1:0]   r_match_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [CNT_W-1:0]   r_first_idx;
  logic [DATA_W-1:0]  r_first_exp;
  logic [DATA_W-1:0]  r_first_got;
  logic               r_first_seen;
  logic               r_err;

  logic               w_accept;
  logic               w_clear;
  logic               w_cmp;
  logic               w_miss;
  logic [DATA_W-1:0]  w_sum;

  // Carry out of the top bit is dropped by the DATA_W-wide assignment.
  assign w_sum    = a_i + b_i;
  assign w_accept = (r_state == S_RUN) && in_valid_i && (r_issued < LP_LEN);
  assign w_clear  = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_cmp    = r_vld[LATENCY-1];
  assign w_miss   = w_cmp && (res_i != r_exp[LATENCY-1]);

  always_comb begin
    // NOTE: next state defaults to the current state first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && (r_issued == LP_LAST)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_vld == '0) w_state_nxt = S_DONE;
      S_DONE:  if (start_i) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    // NOTE: sequential state always uses non-blocking assignments so every flop sees pre-edge values.
    if (!reset_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Alignment pipeline: stage 0 takes the accepted pair, the last stage is compared.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      // NOTE: the pipeline payload is reset along with the valids so a reset leaves no stale data behind.
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_exp[i] <= '0;
        r_idx[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_accept;
      r_exp[0] <= w_sum;
      r_idx[0] <= r_issued;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_exp[i] <= r_exp[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_issued     <= '0;
      r_match_cnt  <= '0;
      r_err_cnt    <= '0;
      r_first_idx  <= '0;
      r_first_exp  <= '0;
      r_first_got  <= '0;
      r_first_seen <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_clear) begin
      r_issued     <= '0;
      r_match_cnt  <= '0;
      r_err_cnt    <= '0;
      r_first_idx  <= '0;
      r_first_exp  <= '0;
      r_first_got  <= '0;
      r_first_seen <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= w_miss;
      if (w_accept && (r_issued != LP_MAX)) r_issued <= r_issued + 1'b1;
      if (w_cmp && !w_miss && (r_match_cnt != LP_MAX)) r_match_cnt <= r_match_cnt + 1'b1;
      if (w_miss && (r_err_cnt != LP_MAX)) r_err_cnt <= r_err_cnt + 1'b1;
      if (w_miss && !r_first_seen) begin
        r_first_seen <= 1'b1;
        r_first_idx  <= r_idx[LATENCY-1];
        r_first_exp  <= r_exp[LATENCY-1];
        r_first_got  <= res_i;
      end
    end
  end

  assign busy_o          = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done_o          = (r_state == S_DONE);
  assign pass_o          = done_o && (r_err_cnt == '0) && (r_match_cnt == LP_LEN);
  assign err_o           = r_err;
  assign match_cnt_o     = r_match_cnt;
  assign err_cnt_o       = r_err_cnt;
  assign first_err_idx_o = r_first_idx;
  assign first_err_exp_o = r_first_exp;
  assign first_err_got_o = r_first_got;

endmodule

// File: tb/tb_res_checker.sv
// Bench for res_checker: two instances (LATENCY 1 and 3, LENGTH 4) fed by a bench-side
// adder model whose results and expected err_o pulses are scheduled through queues.
module tb_res_checker;

  typedef struct {
    int         d;
    int         due;
    logic [7:0] res;
    logic       err;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start    [2];
  logic        in_valid [2];
  logic [7:0]  a_s      [2];
  logic [7:0]  b_s      [2];
  logic [7:0]  res_s    [2];
  logic        busy     [2];
  logic        done     [2];
  logic        pass     [2];
  logic        err      [2];
  logic [31:0] mcnt     [2];
  logic [31:0] ecnt     [2];
  logic [31:0] fidx     [2];
  logic [7:0]  fexp     [2];
  logic [7:0]  fgot     [2];

  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  int    n_pulse [2] = '{0, 0};
  item_t plan_q[$];
  item_t chk_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  res_checker #(.DATA_W(8), .LATENCY(1), .LENGTH(4), .CNT_W(32)) u_lat1 (
    .clk_i(clk), .reset_i(rst_n), .start_i(start[0]), .in_valid_i(in_valid[0]),
    .a_i(a_s[0]), .b_i(b_s[0]), .res_i(res_s[0]),
    .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .err_o(err[0]),
    .match_cnt_o(mcnt[0]), .err_cnt_o(ecnt[0]), .first_err_idx_o(fidx[0]),
    .first_err_exp_o(fexp[0]), .first_err_got_o(fgot[0])
  );

  res_checker #(.DATA_W(8), .LATENCY(3), .LENGTH(4), .CNT_W(32)) u_lat3 (
    .clk_i(clk), .reset_i(rst_n), .start_i(start[1]), .in_valid_i(in_valid[1]),
    .a_i(a_s[1]), .b_i(b_s[1]), .res_i(res_s[1]),
    .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .err_o(err[1]),
    .match_cnt_o(mcnt[1]), .err_cnt_o(ecnt[1]), .first_err_idx_o(fidx[1]),
    .first_err_exp_o(fexp[1]), .first_err_got_o(fgot[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Drive one cycle of stimulus on instance d; acc marks pairs the checker should take.
  task automatic tick(input int d, input logic st, input logic v, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] r, input logic acc);
    logic [8:0] full;
    item_t      it;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      start[k]    = (k == d) ? st : 1'b0;
      in_valid[k] = (k == d) ? v : 1'b0;
      a_s[k]      = a;
      b_s[k]      = b;
    end
    if (acc) begin
      full   = {1'b0, a} + {1'b0, b};
      it.d   = d;
      it.due = cyc + lat(d);
      it.res = r;
      it.err = (r != full[7:0]);
      plan_q.push_back(it);
    end
  endtask

  task automatic idle(input int d);
    tick(d, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic wait_done(input int d, input string tag);
    for (int i = 0; i < 50; i++) begin
      if (done[d]) break;
      idle(d);
    end
    check({tag, "_done"}, 32'(done[d]), 32'd1);
  endtask

  // Per-cycle scoreboard: drive the scheduled result, then score err_o one cycle after compare.
  task automatic mon(input int d);
    logic exp_err;
    int   hit;
    exp_err = 1'b0;
    hit = -1;
    for (int i = 0; i < chk_q.size(); i++)
      if (chk_q[i].d == d && chk_q[i].due == cyc - 1) hit = i;
    if (hit >= 0) begin
      exp_err = chk_q[hit].err;
      chk_q.delete(hit);
    end
    check($sformatf("err_o_dut%0d", d), 32'(err[d]), 32'(exp_err));
    if (err[d]) n_pulse[d]++;
    hit = -1;
    for (int i = 0; i < plan_q.size(); i++)
      if (plan_q[i].d == d && plan_q[i].due == cyc) hit = i;
    if (hit >= 0) begin
      res_s[d] = plan_q[hit].res;
      chk_q.push_back(plan_q[hit]);
      plan_q.delete(hit);
    end else begin
      res_s[d] = 8'hA5;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  task automatic check_cleared(input int d, input string tag);
    check({tag, "_busy"},  32'(busy[d]), 32'd0);
    check({tag, "_done"},  32'(done[d]), 32'd0);
    check({tag, "_pass"},  32'(pass[d]), 32'd0);
    check({tag, "_match"}, mcnt[d], 32'd0);
    check({tag, "_errc"},  ecnt[d], 32'd0);
    check({tag, "_fidx"},  fidx[d], 32'd0);
    check({tag, "_fexp"},  32'(fexp[d]), 32'd0);
    check({tag, "_fgot"},  32'(fgot[d]), 32'd0);
  endtask

  initial begin
    int p0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; in_valid[k] = 1'b0; a_s[k] = '0; b_s[k] = '0; res_s[k] = 8'hA5;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(0);
    check_cleared(0, "reset");
    check_cleared(1, "reset_l3");

    // Test 1: four 1+2 pairs, plus a valid in IDLE that must be ignored.
    tick(0, 1'b0, 1'b1, 8'd9, 8'd9, 8'd0, 1'b0);
    tick(0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    repeat (4) tick(0, 1'b0, 1'b1, 8'd1, 8'd2, 8'd3, 1'b1);
    wait_done(0, "t1");
    check("t1_match", mcnt[0], 32'd4);
    check("t1_errc",  ecnt[0], 32'd0);
    check("t1_pass",  32'(pass[0]), 32'd1);
    check("t1_busy",  32'(busy[0]), 32'd0);

    // Test 2: carry wrap; 300 truncates to 44, 45 is the single error.
    tick(0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    tick(0, 1'b0, 1'b1, 8'd200, 8'd100, 8'd44, 1'b1);
    tick(0, 1'b0, 1'b1, 8'd200, 8'd100, 8'(300), 1'b1);
    tick(0, 1'b0, 1'b1, 8'd200, 8'd100, 8'd45, 1'b1);
    tick(0, 1'b0, 1'b1, 8'd1, 8'd2, 8'd3, 1'b1);
    wait_done(0, "t2");
    check("t2_match", mcnt[0], 32'd3);
    check("t2_errc",  ecnt[0], 32'd1);
    check("t2_fidx",  fidx[0], 32'd2);
    check("t2_fexp",  32'(fexp[0]), 32'd44);
    check("t2_fgot",  32'(fgot[0]), 32'd45);
    check("t2_pass",  32'(pass[0]), 32'd0);
    check("t2_done_hold", 32'(done[0]), 32'd1);

    // Test 6b: start in DONE after a failing run clears everything at once.
    tick(0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    idle(0);
    check("t6_busy",  32'(busy[0]), 32'd1);
    check("t6_done",  32'(done[0]), 32'd0);
    check("t6_match", mcnt[0], 32'd0);
    check("t6_errc",  ecnt[0], 32'd0);
    check("t6_fidx",  fidx[0], 32'd0);
    check("t6_fexp",  32'(fexp[0]), 32'd0);
    check("t6_fgot",  32'(fgot[0]), 32'd0);

    // Test 3 + 6a: errors on transactions 2 and 3; start during RUN is ignored.
    p0 = n_pulse[0];
    tick(0, 1'b0, 1'b1, 8'd1, 8'd2, 8'd3, 1'b1);
    tick(0, 1'b1, 1'b1, 8'd1, 8'd2, 8'd3, 1'b1);
    tick(0, 1'b0, 1'b1, 8'd1, 8'd2, 8'd0, 1'b1);
    tick(0, 1'b0, 1'b1, 8'd1, 8'd2, 8'd0, 1'b1);
    wait_done(0, "t3");
    check("t3_match",  mcnt[0], 32'd2);
    check("t3_errc",   ecnt[0], 32'd2);
    check("t3_fidx",   fidx[0], 32'd2);
    check("t3_fexp",   32'(fexp[0]), 32'd3);
    check("t3_fgot",   32'(fgot[0]), 32'd0);
    check("t3_pulses", 32'(n_pulse[0] - p0), 32'd2);
    check("t3_pass",   32'(pass[0]), 32'd0);

    // Test 5: reset after two of four transactions, then a clean full run.
    tick(0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    tick(0, 1'b0, 1'b1, 8'd5, 8'd6, 8'd11, 1'b1);
    tick(0, 1'b0, 1'b1, 8'd5, 8'd6, 8'd11, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid[0] = 1'b0;
    plan_q.delete();
    chk_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(0);
    check_cleared(0, "t5_rst");
    tick(0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    tick(0, 1'b0, 1'b1, 8'd7, 8'd8, 8'd15, 1'b1);
    tick(0, 1'b0, 1'b1, 8'd9, 8'd9, 8'd18, 1'b1);
    tick(0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b1);
    tick(0, 1'b0, 1'b1, 8'd255, 8'd255, 8'd254, 1'b1);
    wait_done(0, "t5");
    check("t5_match", mcnt[0], 32'd4);
    check("t5_errc",  ecnt[0], 32'd0);
    check("t5_pass",  32'(pass[0]), 32'd1);

    // Test 4: LATENCY 3 with bubbles, back-to-back pairs and six surplus valids.
    tick(1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    tick(1, 1'b0, 1'b1, 8'd10, 8'd20, 8'd30, 1'b1);
    idle(1);
    idle(1);
    tick(1, 1'b0, 1'b1, 8'd3, 8'd4, 8'd7, 1'b1);
    tick(1, 1'b0, 1'b1, 8'd100, 8'd100, 8'd200, 1'b1);
    idle(1);
    tick(1, 1'b0, 1'b1, 8'd255, 8'd1, 8'd0, 1'b1);
    repeat (6) tick(1, 1'b0, 1'b1, 8'd1, 8'd1, 8'd2, 1'b0);
    wait_done(1, "t4");
    check("t4_match", mcnt[1], 32'd4);
    check("t4_errc",  ecnt[1], 32'd0);
    check("t4_pass",  32'(pass[1]), 32'd1);
    check("t4_idle_dut0_done", 32'(done[0]), 32'd1);

    repeat (3) idle(1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/res_checker.md
Name: res_checker

Overview:
- Response-side checker paired with the stimulus driver that feeds operand pairs (A, B) into the adder BFM.
- Snoops each accepted operand pair and computes the expected sum.
- Aligns the expected sum to the DUT result through a LATENCY-deep pipeline and compares it against res_o.
- Reports match/error counts, first-mismatch details and a pass/done verdict once LENGTH transactions have been checked.

Parameters:
- DATA_W, 8: operand/result width.
- LATENCY, 1: cycles from operand sample to valid DUT result; legal range 1..16.
- LENGTH, 2000: number of transactions per run.
- CNT_W, 32: width of all counters and the index field.

Ports:
- clk_i  input  1  single clock; all state on posedge.
- reset_i  input  1  asynchronous, active-low reset; clears all state.
- start_i  input  1  one-cycle pulse; arms a run from IDLE or DONE.
- in_valid_i  input  1  operand pair on a_i/b_i is valid this cycle.
- a_i  input  DATA_W  operand A as driven to the DUT.
- b_i  input  DATA_W  operand B as driven to the DUT.
- res_i  input  DATA_W  DUT result (res_o of the BFM).
- busy_o  output  1  high in RUN or DRAIN.
- done_o  output  1  high in DONE.
- pass_o  output  1  done_o && err_cnt_o==0 && match_cnt_o==LENGTH.
- err_o  output  1  one-cycle pulse on each mismatch.
- match_cnt_o  output  CNT_W  number of matching compares.
- err_cnt_o  output  CNT_W  number of mismatching compares.
- first_err_idx_o  output  CNT_W  transaction index (0-based) of the first mismatch.
- first_err_exp_o  output  DATA_W  expected value at the first mismatch.
- first_err_got_o  output  DATA_W  received value at the first mismatch.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - FSM goes to IDLE; pipeline valids cleared.
  - All counters, first_err_* fields and outputs are 0; first-error latch flag cleared.
  - Reset mid-run aborts the run; nothing is retained.
- FSM states:
  - IDLE: in_valid_i ignored. start_i -> RUN.
  - RUN: a cycle with in_valid_i=1 and issued<LENGTH is accepted and issued increments. When issued reaches LENGTH -> DRAIN. start_i ignored.
  - DRAIN: new in_valid_i ignored. When all pipeline valid bits are 0 and the last compare has completed -> DONE.
  - DONE: outputs hold. start_i clears counters, first_err_* and the first-error latch in the same cycle -> RUN.
- Expected value: (a_i + b_i) mod 2^DATA_W; the carry is discarded (200+100 -> 44).
- Pipeline:
  - Each accepted pair pushes {valid, expected, index} into stage 0; stages shift every cycle.
  - The compare happens when stage LATENCY-1 valid is set, using res_i sampled in that same cycle (i.e. LATENCY cycles after acceptance).
  - Non-accepted cycles insert bubbles; bubbles are not compared.
- Compare outcomes:
  - Equal: match_cnt_o increments.
  - Unequal: err_cnt_o increments and err_o pulses for one cycle, registered in the compare cycle, visible next cycle.
  - On the first mismatch only: capture index, expected and got.
- Counters saturate at 2^CNT_W-1, never wrap.
- Back-to-back valids every cycle must be sustained with no stall; the checker never backpressures.
- done_o/pass_o are asserted from the first DONE cycle and remain until start_i or reset.

Test Plan:
1. LENGTH=4, LATENCY=1; 4 consecutive pairs a=1, b=2 with res_i=3 one cycle later -> match_cnt_o=4, err_cnt_o=0, done_o=1, pass_o=1.
2. Wrap-around: a=200, b=100, res_i=44 -> match. Separately, res_i=300 truncated to 44 is the only accepted value; res_i=45 -> err_cnt_o=1, first_err_exp_o=44, first_err_got_o=45.
3. LENGTH=4, mismatches at transactions 2 and 3 (res_i=0, expected 3) -> err_cnt_o=2, match_cnt_o=2, first_err_idx_o=2, exp=3, got=0, two err_o pulses, pass_o=0.
4. LATENCY=3 with valid gaps (valid, bubble, bubble, valid...) -> each compare occurs exactly 3 cycles after its acceptance; bubbles are never compared; 6 valids beyond LENGTH=4 are ignored; match_cnt_o=4.
5. Drive reset_i low for 1 cycle after 2 of 4 transactions -> all outputs 0, FSM IDLE; a new start_i with a full run gives pass_o=1, match_cnt_o=4.
6. start_i pulsed during RUN -> ignored, counts unaffected. start_i in DONE after a failing run -> counters and first_err_* cleared next cycle, busy_o=1.
